// File: rtl/pipe_add_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor.
// Default geometry, segment-width derivation and the stage register layout.
package pipe_add_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;

  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Stage register layout at the default geometry; the top re-declares the
  // same shape sized by its own WIDTH parameter.
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [DEF_WIDTH-1:0] word;   // result bits below the cut, operand A above
    logic [DEF_WIDTH-1:0] b_op;   // remaining (possibly inverted) operand B
    logic                 a_msb;
    logic                 b_msb;
  } stage_reg_t;

endpackage

// File: rtl/ripple_seg_fa.sv
// Combinational W-bit ripple-carry full adder, one instance per pipeline segment.
module ripple_seg_fa #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  always_comb begin : ripple
    logic c;
    c = cin;
    s = '0;
    for (int i = 0; i < W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/pipe_ripple_addsub.sv
// Pipelined ripple-carry adder/subtractor with valid/ready flow control.
// Optional feature macro: PIPE_ADD_OVF_EN (signed overflow output; tied to 0 otherwise).
module pipe_ripple_addsub
  import pipe_add_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = seg_width(WIDTH, STAGES);

  if ((STAGES < 1) || (STAGES > WIDTH) || (WIDTH % STAGES != 0)) begin : g_bad_geometry
    $error("pipe_ripple_addsub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] b_op;
`ifdef PIPE_ADD_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif
  } stage_t;

  // Handshake: a transfer happens on an edge where valid & ready are both high.
  // The whole pipe shifts together when the output slot is empty or being taken,
  // so in_ready is that same advance signal (combinational from out_ready).
  stage_t st [STAGES+1];
  stage_t r0;
  logic   adv;
  logic   last_sum_msb;

  assign adv      = ~st[STAGES].valid | out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0 <= '0;
    end else if (adv) begin
      r0.valid <= in_valid;
      r0.carry <= sub | cin;
      r0.word  <= a;
      r0.b_op  <= b ^ {WIDTH{sub}};
`ifdef PIPE_ADD_OVF_EN
      r0.a_msb <= a[WIDTH-1];
      r0.b_msb <= b[WIDTH-1] ^ sub;
`endif
    end
  end

  assign st[0] = r0;

  for (genvar j = 0; j < STAGES; j++) begin : g_seg
    logic [SEG-1:0] sum;
    logic           co;
    stage_t         nxt;
    stage_t         q;

    ripple_seg_fa #(.W(SEG)) u_fa (
      .a    (st[j].word[j*SEG +: SEG]),
      .b    (st[j].b_op[j*SEG +: SEG]),
      .cin  (st[j].carry),
      .s    (sum),
      .cout (co)
    );

    // Result bits overwrite the consumed A bits in place; consumed B bits drop to 0.
    always_comb begin
      nxt                     = st[j];
      nxt.word[j*SEG +: SEG]  = sum;
      nxt.b_op[j*SEG +: SEG]  = '0;
      nxt.carry               = co;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q <= '0;
      end else if (adv) begin
        q <= nxt;
      end
    end

    assign st[j+1] = q;

    if (j == STAGES - 1) begin : g_last
      assign last_sum_msb = sum[SEG-1];
    end
  end

  assign out_valid = st[STAGES].valid;
  assign s         = st[STAGES].word;
  assign cout      = st[STAGES].carry;

`ifdef PIPE_ADD_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= (st[STAGES-1].a_msb == st[STAGES-1].b_msb) &
               (last_sum_msb != st[STAGES-1].a_msb);
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_msb;
  assign unused_msb = last_sum_msb;
  assign ovf        = 1'b0;
`endif

endmodule
